// File: rtl/pipe_reg_skid_flush.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// in_ready depends only on state, so a downstream stall never reaches upstream combinationally.
module pipe_reg_skid_flush #(
    parameter int unsigned     BitWidth = 32,
    parameter logic [31:0]     NopValue = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BitWidth-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BitWidth-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                flush,
    output logic [1:0]          occupancy
);

    localparam logic [BitWidth-1:0] Nop = BitWidth'(NopValue);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q;
    logic [BitWidth-1:0]   m_q;
    logic [BitWidth-1:0]   s_q;
    logic                  in_fire;
    logic                  out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_q;
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State encodes occupancy, so the per-entry valid bits are implied by state_q.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= EMPTY;
            m_q     <= Nop;
            s_q     <= Nop;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q <= ONE;
                        m_q     <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_q <= in_data;
                    end else if (in_fire) begin
                        state_q <= FULL;
                        s_q     <= in_data;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                        m_q     <= Nop;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_q <= ONE;
                        m_q     <= s_q;
                        s_q     <= Nop;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    m_q     <= Nop;
                    s_q     <= Nop;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid_flush.sv
// Directed and scoreboarded checks for pipe_reg_skid_flush.
module tb_pipe_reg_skid_flush;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    pipe_reg_skid_flush #(
        .BitWidth(32),
        .NopValue(32'h0000_0013)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flush    (flush),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [31:0] data, input logic valid,
                             input logic rdy, input logic [1:0] occ);
        checks++;
        if (out_data !== data || out_valid !== valid || in_ready !== rdy || occupancy !== occ) begin
            errors++;
            $display("FAIL %s: got data=%h valid=%b in_ready=%b occ=%0d, want data=%h valid=%b in_ready=%b occ=%0d",
                     name, out_data, out_valid, in_ready, occupancy, data, valid, rdy, occ);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_out("reset", 32'h13, 1'b0, 1'b1, 2'd0);
        tick();
        check_out("reset_hold", 32'h13, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_stream();
        logic [31:0] vals [3] = '{32'hA0, 32'hA1, 32'hA2};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            tick();
            check_out($sformatf("stream_%0d", i), vals[i], 1'b1, 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
        check_out("stream_drain", 32'h13, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hB0;
        tick();
        check_out("skid_one", 32'hB0, 1'b1, 1'b1, 2'd1);
        in_data = 32'hB1;
        tick();
        check_out("skid_full", 32'hB0, 1'b1, 1'b0, 2'd2);
        in_valid = 1'b0;
        in_data  = 32'hBBBB;
        tick();
        check_out("skid_stall", 32'hB0, 1'b1, 1'b0, 2'd2);
        out_ready = 1'b1;
        tick();
        check_out("skid_pop1", 32'hB1, 1'b1, 1'b1, 2'd1);
        tick();
        check_out("skid_pop2", 32'h13, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC0;
        tick();
        in_data = 32'hC1;
        tick();
        check_out("flush_full", 32'hC0, 1'b1, 1'b0, 2'd2);
        flush   = 1'b1;
        in_data = 32'hC2;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_out("flush_empty", 32'h13, 1'b0, 1'b1, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("flush_after_%0d", i), 32'h13, 1'b0, 1'b1, 2'd0);
        end
        // Flush while in ONE with an accepted input must also discard it.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC3;
        tick();
        flush   = 1'b1;
        in_data = 32'hC4;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_out("flush_one", 32'h13, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hD0;
        tick();
        in_data = 32'hD1;
        tick();
        check_out("rstfull_full", 32'hD0, 1'b1, 1'b0, 2'd2);
        rst       = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hD2;
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_out("rstfull_reset", 32'h13, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("rstfull_after_%0d", i), 32'h13, 1'b0, 1'b1, 2'd0);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        int          pushed = 0;
        int          popped = 0;
        logic        m_ready;
        logic [31:0] exp_data;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_data   = in_valid ? $urandom() : 32'hFFFF_FFFF;
            m_ready   = (q.size() < 2);
            exp_data  = (q.size() > 0) ? q[0] : 32'h13;
            check_out("random", exp_data, q.size() > 0, m_ready, 2'(q.size()));
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                popped++;
            end
            if (in_valid && m_ready) begin
                q.push_back(in_data);
                pushed++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            check_out("random_drain", q[0], 1'b1, q.size() < 2, 2'(q.size()));
            void'(q.pop_front());
            popped++;
            tick();
        end
        check_out("random_empty", 32'h13, 1'b0, 1'b1, 2'd0);
        checks++;
        if (pushed !== popped || pushed == 0) begin
            errors++;
            $display("FAIL random_count: delivered %0d, accepted %0d", popped, pushed);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_reset_full();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
